// File: rtl/cache_axi_engine_pkg.sv
// Shared constants and FSM state type for the cache line-transfer engine.
package cache_axi_engine_pkg;

    localparam int          CACHELINE_WIDTH = 256;
    localparam logic [7:0]  LEN_LINE        = 8'd7;
    localparam logic [2:0]  SIZE_WORD       = 3'd2;
    localparam logic [1:0]  BURST_INCR      = 2'b01;
    localparam logic [3:0]  WSTRB_FULL      = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WB_RD  = 4'd1,
        S_WB_CAP = 4'd2,
        S_AW     = 4'd3,
        S_W      = 4'd4,
        S_B      = 4'd5,
        S_AR     = 4'd6,
        S_R      = 4'd7,
        S_REFILL = 4'd8
    } state_e;

endpackage

// File: rtl/cache_axi_engine_beat_buf.sv
// Line buffer shared by write-back and refill: parallel load, per-beat word write and read.
module cacheline_beat_buf
    import cache_axi_engine_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en_i,
    input  logic [CACHELINE_WIDTH-1:0] load_line_i,
    input  logic                       wr_en_i,
    input  logic [2:0]                 idx_i,
    input  logic [31:0]                wr_word_i,
    output logic [31:0]                rd_word_o,
    output logic [CACHELINE_WIDTH-1:0] line_o
);

    logic [CACHELINE_WIDTH-1:0] line_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else if (load_en_i) begin
            line_q <= load_line_i;
        end else if (wr_en_i) begin
            line_q[idx_i*32 +: 32] <= wr_word_i;
        end
    end

    assign rd_word_o = line_q[idx_i*32 +: 32];
    assign line_o    = line_q;

endmodule

// File: rtl/cache_axi_engine.sv
// Miss engine: optional dirty-victim write burst, then line fetch burst, then one-cycle refresh.
// States: IDLE wait | WB_RD/WB_CAP read victim | AW/W/B write burst | AR/R read burst | REFILL hand off
module cache_axi_engine
    import cache_axi_engine_pkg::*;
#(
    parameter logic [3:0] AXI_ID     = 4'b0001,
    parameter int         LINE_WORDS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    input  logic [31:0]                req_addr,
    input  logic                       req_dirty,
    input  logic [31:0]                req_victim_addr,
    output logic                       req_ready,
    output logic                       write_back,
    input  logic [CACHELINE_WIDTH-1:0] cacheline_old,
    output logic                       refresh,
    output logic [CACHELINE_WIDTH-1:0] cacheline_new,
    output logic                       done,
    output logic [3:0]                 arid,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [3:0]                 rid,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready,
    output logic [3:0]                 awid,
    output logic [31:0]                awaddr,
    output logic [7:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [3:0]                 wid,
    output logic [31:0]                wdata,
    output logic [3:0]                 wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic [3:0]                 bid,
    input  logic [1:0]                 bresp,
    input  logic                       bvalid,
    output logic                       bready
);

    localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);

    state_e      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic [31:0] line_addr_q, victim_addr_q;
    logic        buf_load, buf_wr;
    logic [31:0] buf_rd_word;

    // The burst length alone ends a transfer; response ids/status and sub-line address bits are don't-care.
    logic unused_ok;
    assign unused_ok = ^{rid, rresp, rlast, bid, bresp, req_addr[4:0], req_victim_addr[4:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            line_addr_q   <= '0;
            victim_addr_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (req_valid && state_q == S_IDLE) begin
                line_addr_q   <= {req_addr[31:5], 5'b0};
                victim_addr_q <= {req_victim_addr[31:5], 5'b0};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        req_ready  = 1'b0;
        write_back = 1'b0;
        refresh    = 1'b0;
        done       = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        buf_load   = 1'b0;
        buf_wr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_dirty ? S_WB_RD : S_AR;
            end
            S_WB_RD: begin
                write_back = 1'b1;
                state_d    = S_WB_CAP;
            end
            S_WB_CAP: begin
                buf_load = 1'b1;
                state_d  = S_AW;
            end
            S_AW: begin
                awvalid = 1'b1;
                if (awready) state_d = S_W;
            end
            S_W: begin
                wvalid = 1'b1;
                wlast  = (beat_q == LAST_BEAT);
                if (wready) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == LAST_BEAT) state_d = S_B;
                end
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) state_d = S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    buf_wr = 1'b1;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == LAST_BEAT) state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                refresh = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    cacheline_beat_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .load_en_i   (buf_load),
        .load_line_i (cacheline_old),
        .wr_en_i     (buf_wr),
        .idx_i       (beat_q),
        .wr_word_i   (rdata),
        .rd_word_o   (buf_rd_word),
        .line_o      (cacheline_new)
    );

    assign wdata   = buf_rd_word;
    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign araddr  = line_addr_q;
    assign awaddr  = victim_addr_q;
    assign arlen   = LEN_LINE;
    assign awlen   = LEN_LINE;
    assign arsize  = SIZE_WORD;
    assign awsize  = SIZE_WORD;
    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign wstrb   = WSTRB_FULL;

endmodule

// File: tb/tb_cache_axi_engine.sv
// Directed bench for cache_axi_engine with a small AXI slave model and a vector table of misses.
module tb_cache_axi_engine;
    import cache_axi_engine_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_dirty, req_ready;
    logic [31:0]  req_addr, req_victim_addr;
    logic         write_back, refresh, done;
    logic [255:0] cacheline_old, cacheline_new;
    logic [3:0]   arid, awid, wid, rid, bid;
    logic [31:0]  araddr, awaddr, rdata, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst, rresp, bresp;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]   wstrb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_axi_engine dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_dirty(req_dirty),
        .req_victim_addr(req_victim_addr), .req_ready(req_ready),
        .write_back(write_back), .cacheline_old(cacheline_old),
        .refresh(refresh), .cacheline_new(cacheline_new), .done(done),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic        dirty;
        logic [31:0] addr;
        logic [31:0] victim;
        logic [31:0] rbase;
        logic [31:0] obase;
        logic [31:0] exp_araddr;
        logic [31:0] exp_awaddr;
        int          aw_delay;
        bit          w_toggle;
        int          r_gap;
        int          exp_ar;
        int          exp_refresh;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic idle_slave();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; rdata = '0;
        bvalid = 1'b0; cacheline_old = '0;
    endtask

    // Runs one miss from acceptance; starts and ends 1 time unit after a rising edge.
    task automatic run_txn(input vec_t v, input bit hold_next, input logic [31:0] next_addr,
                           input int abort_beat, input string name);
        int cyc, aw_wait, wbeat, rsent, gap, viol, werr;
        int ar_cyc, wb_cyc, ref_cyc;
        bit bpend, bdone, arpend, ar_early, aw_chk, ar_chk;
        bit prev_wb, prev_aw_stall, prev_ar_stall, prev_w_stall, w_fire, last_fire;
        logic [31:0] prev_wdata;
        aw_wait = 0; wbeat = 0; rsent = 0; gap = 0; viol = 0; werr = 0;
        ar_cyc = -1; wb_cyc = -1; ref_cyc = -1;
        bpend = 0; bdone = 0; arpend = 0; ar_early = 0; aw_chk = 0; ar_chk = 0;
        prev_wb = 0; prev_aw_stall = 0; prev_ar_stall = 0; prev_w_stall = 0;
        prev_wdata = '0;

        req_valid = 1'b1; req_addr = v.addr; req_dirty = v.dirty; req_victim_addr = v.victim;
        idle_slave();
        check({name, "_req_ready"}, 256'(req_ready), 256'(1));
        @(posedge clk); #1;
        if (hold_next) begin
            req_addr = next_addr; req_dirty = 1'b0;
        end else begin
            req_valid = 1'b0;
        end
        cyc = 1;
        while (cyc < 400) begin
            cacheline_old = prev_wb ? mk_line(v.obase) : {8{32'hDEAD_BEEF}};
            awready = awvalid && (aw_wait >= v.aw_delay);
            wready  = v.w_toggle ? (cyc % 2 == 1) : 1'b1;
            bvalid  = bpend;
            arready = 1'b1;
            rvalid  = arpend && (rsent < 8) && (gap == 0);
            rdata   = v.rbase + 32'(rsent);
            rlast   = (rsent == 7);

            if (abort_beat >= 0 && rvalid && rsent == abort_beat) begin
                rst = 1'b1;
                #1;
                check({name, "_rst_ctrl"},
                      256'({req_ready, arvalid, rready, refresh, done, write_back, wvalid, awvalid, bready}),
                      256'(9'b1_0000_0000));
                check({name, "_rst_line"}, cacheline_new, '0);
                idle_slave();
                @(posedge clk); #1;
                rst = 1'b0;
                @(posedge clk); #1;
                return;
            end

            if (prev_aw_stall && !awvalid) viol++;
            if (prev_ar_stall && !arvalid) viol++;
            if (prev_w_stall && (!wvalid || wdata !== prev_wdata)) viol++;
            if (hold_next && ref_cyc < 0 && req_ready) viol++;
            if (write_back && wb_cyc < 0) wb_cyc = cyc;
            if (awvalid && !aw_chk) begin
                aw_chk = 1;
                check({name, "_awaddr"}, 256'(awaddr), 256'(v.exp_awaddr));
                check({name, "_aw_fields"}, 256'({awid, awlen, awsize, awburst}),
                      256'({4'b0001, 8'd7, 3'd2, 2'b01}));
            end
            w_fire = wvalid && wready;
            last_fire = w_fire && wlast;
            if (w_fire) begin
                if (wdata !== v.obase + 32'(wbeat) || wlast !== (wbeat == 7) || wstrb !== 4'hF) werr++;
                wbeat++;
            end
            if (arvalid) begin
                if (ar_cyc < 0) ar_cyc = cyc;
                if (v.dirty && !bdone) ar_early = 1;
            end
            if (arvalid && !ar_chk) begin
                ar_chk = 1;
                check({name, "_araddr"}, 256'(araddr), 256'(v.exp_araddr));
                check({name, "_ar_fields"}, 256'({arid, arlen, arsize, arburst}),
                      256'({4'b0001, 8'd7, 3'd2, 2'b01}));
            end
            if (refresh) begin
                ref_cyc = cyc;
                check({name, "_done_with_refresh"}, 256'(done), 256'(1));
                check({name, "_line"}, cacheline_new, mk_line(v.rbase));
                check({name, "_rbeats"}, 256'(rsent), 256'(8));
            end else if (ref_cyc >= 0 && cyc == ref_cyc + 1) begin
                check({name, "_after_done"}, 256'({done, refresh, req_ready}), 256'(3'b001));
                check({name, "_line_held"}, cacheline_new, mk_line(v.rbase));
                break;
            end

            prev_wb       = write_back;
            prev_aw_stall = awvalid && !awready;
            prev_ar_stall = arvalid && !arready;
            prev_w_stall  = wvalid && !wready;
            prev_wdata    = wdata;
            if (awvalid) aw_wait++;
            if (last_fire) bpend = 1;
            if (bvalid && bready) begin
                bpend = 0; bdone = 1;
            end
            if (arvalid && arready) arpend = 1;
            if (rvalid && rready) begin
                rsent++; gap = v.r_gap;
            end else if (gap > 0) begin
                gap--;
            end
            @(posedge clk); #1;
            cyc++;
        end
        idle_slave();
        check({name, "_completed"}, 256'(ref_cyc >= 0), 256'(1));
        if (abort_beat >= 0) check({name, "_abort_reached"}, 256'(0), 256'(1));
        check({name, "_valid_hold"}, 256'(viol), 256'(0));
        check({name, "_wdata"}, 256'(werr), 256'(0));
        check({name, "_wbeats"}, 256'(wbeat), 256'(v.dirty ? 8 : 0));
        check({name, "_ar_after_b"}, 256'(ar_early), 256'(0));
        if (v.exp_refresh >= 0) begin
            check({name, "_ar_cycle"}, 256'(ar_cyc), 256'(v.exp_ar));
            check({name, "_refresh_cycle"}, 256'(ref_cyc), 256'(v.exp_refresh));
            if (v.dirty) check({name, "_wb_cycle"}, 256'(wb_cyc), 256'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t vecs[4];
        vec_t h1, h2, a1, a2;
        vecs[0] = '{1'b0, 32'h1FC0_0124, 32'h0000_0000, 32'h0000_00A0, 32'h0, 32'h1FC0_0120, 32'h0, 0, 1'b0, 0, 1, 10};
        vecs[1] = '{1'b1, 32'h0000_1010, 32'h0000_3040, 32'h0000_0200, 32'h10, 32'h0000_1000, 32'h0000_3040, 0, 1'b0, 0, 13, 22};
        vecs[2] = '{1'b1, 32'h2345_67FC, 32'h0000_305C, 32'h0000_5000, 32'h7700, 32'h2345_67E0, 32'h0000_3040, 3, 1'b1, 2, -1, -1};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFE0, 32'h0, 0, 1'b0, 0, 1, 10};
        h1 = '{1'b0, 32'h0000_8004, 32'h0, 32'h0000_0300, 32'h0, 32'h0000_8000, 32'h0, 0, 1'b0, 0, 1, 10};
        h2 = '{1'b0, 32'h0000_9FFF, 32'h0, 32'h0000_0400, 32'h0, 32'h0000_9FE0, 32'h0, 0, 1'b0, 0, 1, 10};
        a1 = '{1'b0, 32'h0000_4444, 32'h0, 32'h0000_0600, 32'h0, 32'h0000_4440, 32'h0, 0, 1'b0, 0, 1, 10};
        a2 = '{1'b0, 32'h0000_5550, 32'h0, 32'h0000_0700, 32'h0, 32'h0000_5540, 32'h0, 0, 1'b0, 0, 1, 10};

        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_dirty = 1'b0; req_victim_addr = '0;
        rid = 4'h1; rresp = 2'b00; bid = 4'h1; bresp = 2'b00;
        idle_slave();
        #12;
        check("reset_ctrl",
              256'({req_ready, arvalid, rready, refresh, done, write_back, wvalid, awvalid, bready}),
              256'(9'b1_0000_0000));
        check("reset_line", cacheline_new, '0);
        check("fixed_fields", 256'({arid, awid, wid, arlen, awlen, arsize, awsize, arburst, awburst, wstrb}),
              256'({4'h1, 4'h1, 4'h1, 8'd7, 8'd7, 3'd2, 3'd2, 2'b01, 2'b01, 4'hF}));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) run_txn(vecs[i], 1'b0, 32'h0, -1, $sformatf("vec%0d", i));

        run_txn(h1, 1'b1, 32'h0000_9FFF, -1, "hold_first");
        run_txn(h2, 1'b0, 32'h0, -1, "hold_second");

        run_txn(a1, 1'b0, 32'h0, 4, "abort");
        run_txn(a2, 1'b0, 32'h0, -1, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
